// File: rtl/llc_set_fill_pkg.sv
// Shared types and constants for the LLC set fill stage.
// Field widths, per-way entry record and the fill FSM encoding.
package llc_set_fill_pkg;

   localparam int unsigned WAYS      = 16;
   localparam int unsigned WAY_W     = 4;
   localparam int unsigned SET_W     = 9;
   localparam int unsigned TAG_W     = 15;
   localparam int unsigned LINE_W    = 128;
   localparam int unsigned STATE_W   = 3;
   localparam int unsigned HPROT_W   = 1;
   localparam int unsigned SHARERS_W = 16;
   localparam int unsigned OWNER_W   = 4;

   typedef logic [TAG_W-1:0]     llc_tag_t;
   typedef logic [STATE_W-1:0]   llc_state_t;
   typedef logic [LINE_W-1:0]    line_t;
   typedef logic [HPROT_W-1:0]   hprot_t;
   typedef logic [SHARERS_W-1:0] sharers_t;
   typedef logic [OWNER_W-1:0]   owner_t;
   typedef logic [WAY_W-1:0]     llc_way_t;
   typedef logic [SET_W-1:0]     llc_set_t;

   localparam llc_state_t INVALID = '0;

   typedef struct packed {
      llc_tag_t   tag;
      llc_state_t state;
      line_t      line;
      hprot_t     hprot;
      sharers_t   sharers;
      owner_t     owner;
      logic       dirty;
   } way_entry_t;

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StCapture,
      StLookup,
      StDone
   } fill_state_e;

endpackage

// File: rtl/llc_way_select.sv
// Lowest-index-first priority encoder over a per-way flag vector.
module llc_way_select
   import llc_set_fill_pkg::*;
(
   input  logic [WAYS-1:0]  vec,
   output logic             valid,
   output logic [WAY_W-1:0] way
);

   always_comb begin
      valid = |vec;
      way   = '0;
      // Walk downwards so the lowest set index is the last one written.
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (vec[i]) way = WAY_W'(i);
      end
   end

endmodule

// File: rtl/llc_set_fill.sv
// LLC set fill: reads all ways of one set, merges in-flight write-backs,
// then computes hit / empty / evict way and holds the set until acknowledged.
module llc_set_fill
   import llc_set_fill_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [SET_W-1:0]          req_set,
   input  logic [TAG_W-1:0]          req_tag,
   output logic                      rd_en,
   output logic [SET_W-1:0]          rd_set,
   input  logic [WAYS*TAG_W-1:0]     rd_tags,
   input  logic [WAYS*STATE_W-1:0]   rd_states,
   input  logic [WAYS*LINE_W-1:0]    rd_lines,
   input  logic [WAYS*HPROT_W-1:0]   rd_hprots,
   input  logic [WAYS*SHARERS_W-1:0] rd_sharers,
   input  logic [WAYS*OWNER_W-1:0]   rd_owners,
   input  logic [WAYS-1:0]           rd_dirty,
   input  logic [WAY_W-1:0]          rd_evict_way,
   input  logic                      wr_en,
   input  logic [SET_W-1:0]          wr_set,
   input  logic [WAY_W-1:0]          wr_way,
   input  logic [TAG_W-1:0]          wr_tag,
   input  logic [STATE_W-1:0]        wr_state,
   input  logic [LINE_W-1:0]         wr_line,
   input  logic [HPROT_W-1:0]        wr_hprot,
   input  logic [SHARERS_W-1:0]      wr_sharers,
   input  logic [OWNER_W-1:0]        wr_owner,
   input  logic                      wr_dirty,
   output logic [WAYS*TAG_W-1:0]     tags_buf,
   output logic [WAYS*STATE_W-1:0]   states_buf,
   output logic [WAYS*LINE_W-1:0]    lines_buf,
   output logic [WAYS*HPROT_W-1:0]   hprots_buf,
   output logic [WAYS*SHARERS_W-1:0] sharers_buf,
   output logic [WAYS*OWNER_W-1:0]   owners_buf,
   output logic [WAYS-1:0]           dirty_bits_buf,
   output logic [WAY_W-1:0]          evict_way_buf,
   output logic                      bufs_valid,
   input  logic                      bufs_ack,
   output logic                      hit,
   output logic [WAY_W-1:0]          hit_way,
   output logic                      empty_valid,
   output logic [WAY_W-1:0]          empty_way,
   output logic [WAY_W-1:0]          evict_way,
   output logic                      hazard_err
);

   fill_state_e              state_q, state_d;
   llc_set_t                 set_q;
   llc_tag_t                 tag_q;
   way_entry_t [WAYS-1:0]    buf_q, buf_d;
   llc_way_t                 evict_buf_q, evict_buf_d;
   logic                     pend_valid_q;
   llc_way_t                 pend_way_q;
   way_entry_t               pend_q;
   way_entry_t               wr_entry;
   logic                     wr_hit;
   logic [WAYS-1:0]          hit_vec, empty_vec;
   logic                     hit_any, empty_any;
   llc_way_t                 hit_sel_way, empty_sel_way;
   logic                     hit_q, empty_valid_q, hazard_q;
   llc_way_t                 hit_way_q, empty_way_q, evict_way_q;

   assign wr_hit   = wr_en && (wr_set == set_q);
   assign wr_entry = '{tag: wr_tag, state: wr_state, line: wr_line, hprot: wr_hprot,
                       sharers: wr_sharers, owner: wr_owner, dirty: wr_dirty};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (req_valid) state_d = StRead;
         StRead:    state_d = StCapture;
         StCapture: state_d = StLookup;
         StLookup:  state_d = StDone;
         StDone:    if (bufs_ack) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready  = (state_q == StIdle);
      rd_en      = (state_q == StRead);
      bufs_valid = (state_q == StDone);
   end

   // Memory is read-before-write: a READ-cycle write is replayed here, then a
   // same-cycle write lands on top of it.
   always_comb begin
      buf_d       = buf_q;
      evict_buf_d = evict_buf_q;
      if (state_q == StCapture) begin
         for (int i = 0; i < WAYS; i++) begin
            buf_d[i].tag     = rd_tags[i*TAG_W +: TAG_W];
            buf_d[i].state   = rd_states[i*STATE_W +: STATE_W];
            buf_d[i].line    = rd_lines[i*LINE_W +: LINE_W];
            buf_d[i].hprot   = rd_hprots[i*HPROT_W +: HPROT_W];
            buf_d[i].sharers = rd_sharers[i*SHARERS_W +: SHARERS_W];
            buf_d[i].owner   = rd_owners[i*OWNER_W +: OWNER_W];
            buf_d[i].dirty   = rd_dirty[i];
         end
         evict_buf_d = rd_evict_way;
         if (pend_valid_q) buf_d[pend_way_q] = pend_q;
         if (wr_hit)       buf_d[wr_way]     = wr_entry;
      end
   end

   always_comb begin
      for (int i = 0; i < WAYS; i++) begin
         hit_vec[i]   = (buf_q[i].state != INVALID) && (buf_q[i].tag == tag_q);
         empty_vec[i] = (buf_q[i].state == INVALID);
      end
   end

   llc_way_select u_hit_sel (
      .vec   (hit_vec),
      .valid (hit_any),
      .way   (hit_sel_way)
   );

   llc_way_select u_empty_sel (
      .vec   (empty_vec),
      .valid (empty_any),
      .way   (empty_sel_way)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         set_q         <= '0;
         tag_q         <= '0;
         buf_q         <= '0;
         evict_buf_q   <= '0;
         pend_valid_q  <= 1'b0;
         pend_way_q    <= '0;
         pend_q        <= '0;
         hit_q         <= 1'b0;
         hit_way_q     <= '0;
         empty_valid_q <= 1'b0;
         empty_way_q   <= '0;
         evict_way_q   <= '0;
         hazard_q      <= 1'b0;
      end else begin
         if (state_q == StIdle && req_valid) begin
            set_q <= req_set;
            tag_q <= req_tag;
         end
         if (state_q == StRead && wr_hit) begin
            pend_valid_q <= 1'b1;
            pend_way_q   <= wr_way;
            pend_q       <= wr_entry;
         end else if (state_q == StCapture) begin
            pend_valid_q <= 1'b0;
         end
         buf_q       <= buf_d;
         evict_buf_q <= evict_buf_d;
         if (state_q == StLookup) begin
            hit_q         <= hit_any;
            hit_way_q     <= hit_sel_way;
            empty_valid_q <= empty_any;
            empty_way_q   <= empty_sel_way;
            evict_way_q   <= empty_any ? empty_sel_way : evict_buf_q;
         end
         if ((state_q == StLookup || state_q == StDone) && wr_hit) hazard_q <= 1'b1;
      end
   end

   always_comb begin
      tags_buf       = '0;
      states_buf     = '0;
      lines_buf      = '0;
      hprots_buf     = '0;
      sharers_buf    = '0;
      owners_buf     = '0;
      dirty_bits_buf = '0;
      for (int i = 0; i < WAYS; i++) begin
         tags_buf[i*TAG_W +: TAG_W]             = buf_q[i].tag;
         states_buf[i*STATE_W +: STATE_W]       = buf_q[i].state;
         lines_buf[i*LINE_W +: LINE_W]          = buf_q[i].line;
         hprots_buf[i*HPROT_W +: HPROT_W]       = buf_q[i].hprot;
         sharers_buf[i*SHARERS_W +: SHARERS_W]  = buf_q[i].sharers;
         owners_buf[i*OWNER_W +: OWNER_W]       = buf_q[i].owner;
         dirty_bits_buf[i]                      = buf_q[i].dirty;
      end
   end

   assign rd_set        = set_q;
   assign evict_way_buf = evict_buf_q;
   assign hit           = hit_q;
   assign hit_way       = hit_way_q;
   assign empty_valid   = empty_valid_q;
   assign empty_way     = empty_way_q;
   assign evict_way     = evict_way_q;
   assign hazard_err    = hazard_q;

endmodule

// File: tb/tb_llc_set_fill.sv
// Self-checking bench for llc_set_fill: expected lookup results are queued
// per request and compared when the set buffers become valid.
module tb_llc_set_fill;
   import llc_set_fill_pkg::*;

   logic                      clk, rst;
   logic                      req_valid, req_ready;
   logic [SET_W-1:0]          req_set;
   logic [TAG_W-1:0]          req_tag;
   logic                      rd_en;
   logic [SET_W-1:0]          rd_set;
   logic [WAYS*TAG_W-1:0]     rd_tags;
   logic [WAYS*STATE_W-1:0]   rd_states;
   logic [WAYS*LINE_W-1:0]    rd_lines;
   logic [WAYS*HPROT_W-1:0]   rd_hprots;
   logic [WAYS*SHARERS_W-1:0] rd_sharers;
   logic [WAYS*OWNER_W-1:0]   rd_owners;
   logic [WAYS-1:0]           rd_dirty;
   logic [WAY_W-1:0]          rd_evict_way;
   logic                      wr_en;
   logic [SET_W-1:0]          wr_set;
   logic [WAY_W-1:0]          wr_way;
   logic [TAG_W-1:0]          wr_tag;
   logic [STATE_W-1:0]        wr_state;
   logic [LINE_W-1:0]         wr_line;
   logic [HPROT_W-1:0]        wr_hprot;
   logic [SHARERS_W-1:0]      wr_sharers;
   logic [OWNER_W-1:0]        wr_owner;
   logic                      wr_dirty;
   logic [WAYS*TAG_W-1:0]     tags_buf;
   logic [WAYS*STATE_W-1:0]   states_buf;
   logic [WAYS*LINE_W-1:0]    lines_buf;
   logic [WAYS*HPROT_W-1:0]   hprots_buf;
   logic [WAYS*SHARERS_W-1:0] sharers_buf;
   logic [WAYS*OWNER_W-1:0]   owners_buf;
   logic [WAYS-1:0]           dirty_bits_buf;
   logic [WAY_W-1:0]          evict_way_buf;
   logic                      bufs_valid, bufs_ack;
   logic                      hit, empty_valid, hazard_err;
   logic [WAY_W-1:0]          hit_way, empty_way, evict_way;

   typedef struct packed {
      logic       hit;
      llc_way_t   hit_way;
      logic       empty_valid;
      llc_way_t   empty_way;
      llc_way_t   evict_way;
      llc_way_t   chk_way;
      way_entry_t chk_ent;
   } exp_t;

   exp_t       sb[$];
   int         n_cmp = 0;
   int         n_fail = 0;
   way_entry_t nul_e = '0;

   llc_tag_t   m_tag[WAYS];
   llc_state_t m_state[WAYS];
   line_t      m_line[WAYS];
   hprot_t     m_hprot[WAYS];
   sharers_t   m_sharers[WAYS];
   owner_t     m_owner[WAYS];
   logic       m_dirty[WAYS];
   llc_way_t   m_evict;

   llc_set_fill dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set), .req_tag(req_tag),
      .rd_en(rd_en), .rd_set(rd_set),
      .rd_tags(rd_tags), .rd_states(rd_states), .rd_lines(rd_lines), .rd_hprots(rd_hprots),
      .rd_sharers(rd_sharers), .rd_owners(rd_owners), .rd_dirty(rd_dirty),
      .rd_evict_way(rd_evict_way),
      .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way), .wr_tag(wr_tag), .wr_state(wr_state),
      .wr_line(wr_line), .wr_hprot(wr_hprot), .wr_sharers(wr_sharers), .wr_owner(wr_owner),
      .wr_dirty(wr_dirty),
      .tags_buf(tags_buf), .states_buf(states_buf), .lines_buf(lines_buf),
      .hprots_buf(hprots_buf), .sharers_buf(sharers_buf), .owners_buf(owners_buf),
      .dirty_bits_buf(dirty_bits_buf), .evict_way_buf(evict_way_buf),
      .bufs_valid(bufs_valid), .bufs_ack(bufs_ack),
      .hit(hit), .hit_way(hit_way), .empty_valid(empty_valid), .empty_way(empty_way),
      .evict_way(evict_way), .hazard_err(hazard_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: data appears one cycle after the read strobe.
   always @(posedge clk) begin
      if (rd_en) begin
         for (int i = 0; i < WAYS; i++) begin
            rd_tags[i*TAG_W +: TAG_W]            <= m_tag[i];
            rd_states[i*STATE_W +: STATE_W]      <= m_state[i];
            rd_lines[i*LINE_W +: LINE_W]         <= m_line[i];
            rd_hprots[i*HPROT_W +: HPROT_W]      <= m_hprot[i];
            rd_sharers[i*SHARERS_W +: SHARERS_W] <= m_sharers[i];
            rd_owners[i*OWNER_W +: OWNER_W]      <= m_owner[i];
            rd_dirty[i]                          <= m_dirty[i];
         end
         rd_evict_way <= m_evict;
      end
   end

   function automatic way_entry_t mem_ent(input int w);
      return '{tag: m_tag[w], state: m_state[w], line: m_line[w], hprot: m_hprot[w],
               sharers: m_sharers[w], owner: m_owner[w], dirty: m_dirty[w]};
   endfunction

   function automatic way_entry_t buf_ent(input int w);
      return '{tag: tags_buf[w*TAG_W +: TAG_W], state: states_buf[w*STATE_W +: STATE_W],
               line: lines_buf[w*LINE_W +: LINE_W], hprot: hprots_buf[w*HPROT_W +: HPROT_W],
               sharers: sharers_buf[w*SHARERS_W +: SHARERS_W],
               owner: owners_buf[w*OWNER_W +: OWNER_W], dirty: dirty_bits_buf[w]};
   endfunction

   function automatic way_entry_t mk_ent(input llc_tag_t t, input llc_state_t s, input line_t l);
      return '{tag: t, state: s, line: l, hprot: 1'b1, sharers: 16'ha5c3, owner: 4'h9,
               dirty: 1'b1};
   endfunction

   function automatic line_t rnd_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic fill_mem(input llc_state_t st, input int tag_base, input llc_way_t ev);
      for (int i = 0; i < WAYS; i++) begin
         m_tag[i]     = llc_tag_t'(tag_base + i);
         m_state[i]   = st;
         m_line[i]    = rnd_line();
         m_hprot[i]   = hprot_t'($urandom_range(1, 0));
         m_sharers[i] = sharers_t'($urandom);
         m_owner[i]   = owner_t'($urandom);
         m_dirty[i]   = 1'($urandom_range(1, 0));
      end
      m_evict = ev;
   endtask

   task automatic drive_wr(input logic en, input llc_set_t s, input llc_way_t w,
                           input way_entry_t e);
      wr_en = en; wr_set = s; wr_way = w;
      wr_tag = e.tag; wr_state = e.state; wr_line = e.line; wr_hprot = e.hprot;
      wr_sharers = e.sharers; wr_owner = e.owner; wr_dirty = e.dirty;
   endtask

   task automatic ack_done();
      bufs_ack = 1'b1;
      @(posedge clk); #1;
      bufs_ack = 1'b0;
      n_cmp++;
      if (bufs_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ack_release: bufs_valid=%b req_ready=%b, required 0/1", bufs_valid,
                  req_ready);
      end
   endtask

   // One request end to end; optional write-backs in READ (fr_*) and CAPTURE (fc_*).
   task automatic run_req(input llc_set_t s, input llc_tag_t t,
                          input logic fr_en, input llc_set_t fr_set, input llc_way_t fr_way,
                          input way_entry_t fr_e,
                          input logic fc_en, input llc_set_t fc_set, input llc_way_t fc_way,
                          input way_entry_t fc_e, input logic hold);
      exp_t e;
      int   waited;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1 || rd_en !== 1'b0) begin
         n_fail++;
         $display("FAIL idle: req_ready=%b rd_en=%b, required 1/0", req_ready, rd_en);
      end
      req_valid = 1'b1; req_set = s; req_tag = t;
      @(posedge clk); #1;
      req_valid = 1'b0; req_set = ~s; req_tag = ~t;
      n_cmp++;
      if (rd_en !== 1'b1 || rd_set !== s || req_ready !== 1'b0 || bufs_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL read_cycle: rd_en=%b rd_set=%0d ready=%b valid=%b, required 1/%0d/0/0",
                  rd_en, rd_set, req_ready, bufs_valid, s);
      end
      drive_wr(fr_en, fr_set, fr_way, fr_e);
      bufs_ack = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (rd_en !== 1'b0 || bufs_valid !== 1'b0 || req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL capture_cycle: rd_en=%b valid=%b ready=%b, required 0/0/0", rd_en,
                  bufs_valid, req_ready);
      end
      drive_wr(fc_en, fc_set, fc_way, fc_e);
      @(posedge clk); #1;
      drive_wr(1'b0, '0, '0, nul_e);
      bufs_ack = 1'b0;
      n_cmp++;
      if (rd_en !== 1'b0 || bufs_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL lookup_cycle: rd_en=%b valid=%b, required 0/0", rd_en, bufs_valid);
      end
      @(posedge clk); #1;
      waited = 0;
      while (bufs_valid !== 1'b1 && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      n_cmp++;
      if (waited != 0 || bufs_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL latency: bufs_valid=%b after %0d extra cycles, required 1 after 0",
                  bufs_valid, waited);
      end
      n_cmp++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard: queue empty, required one entry");
      end else begin
         e = sb.pop_front();
         if (hit !== e.hit || (e.hit && hit_way !== e.hit_way)) begin
            n_fail++;
            $display("FAIL hit: got %b/%0d, required %b/%0d", hit, hit_way, e.hit, e.hit_way);
         end
         n_cmp++;
         if (empty_valid !== e.empty_valid || (e.empty_valid && empty_way !== e.empty_way)) begin
            n_fail++;
            $display("FAIL empty: got %b/%0d, required %b/%0d", empty_valid, empty_way,
                     e.empty_valid, e.empty_way);
         end
         n_cmp++;
         if (evict_way !== e.evict_way) begin
            n_fail++;
            $display("FAIL evict_way: got %0d, required %0d", evict_way, e.evict_way);
         end
         n_cmp++;
         if (buf_ent(int'(e.chk_way)) !== e.chk_ent) begin
            n_fail++;
            $display("FAIL buf_way%0d: got %h, required %h", e.chk_way,
                     buf_ent(int'(e.chk_way)), e.chk_ent);
         end
      end
      if (!hold) ack_done();
   endtask

   task automatic test_reset();
      rst = 1'b0; req_valid = 1'b0; req_set = '0; req_tag = '0; bufs_ack = 1'b0;
      drive_wr(1'b0, '0, '0, nul_e);
      #1 rst = 1'b1;
      #12;
      n_cmp++;
      if (bufs_valid !== 1'b0 || rd_en !== 1'b0 || hazard_err !== 1'b0 || hit !== 1'b0 ||
          tags_buf !== '0 || lines_buf !== '0 || evict_way !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%b rd_en=%b hazard=%b hit=%b, required all 0",
                  bufs_valid, rd_en, hazard_err, hit);
      end
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: req_ready=%b, required 1", req_ready);
      end
   endtask

   task automatic setup_hit3();
      fill_mem(INVALID, 'h40, 4'd9);
      m_tag[3] = 15'h12; m_state[3] = 3'd1;
   endtask

   task automatic test_hit();
      setup_hit3();
      sb.push_back('{hit: 1'b1, hit_way: 4'd3, empty_valid: 1'b1, empty_way: 4'd0,
                     evict_way: 4'd0, chk_way: 4'd3, chk_ent: mem_ent(3)});
      run_req(9'd5, 15'h12, 1'b0, '0, '0, nul_e, 1'b0, '0, '0, nul_e, 1'b0);
   endtask

   task automatic test_miss_evict();
      fill_mem(3'd2, 'h100, 4'd7);
      sb.push_back('{hit: 1'b0, hit_way: 4'd0, empty_valid: 1'b0, empty_way: 4'd0,
                     evict_way: 4'd7, chk_way: 4'd7, chk_ent: mem_ent(7)});
      run_req(9'd5, 15'h12, 1'b0, '0, '0, nul_e, 1'b0, '0, '0, nul_e, 1'b0);
      // Lowest match wins; an INVALID way with the same tag must not hit.
      fill_mem(3'd1, 'h300, 4'd2);
      m_tag[5] = 15'h33; m_tag[13] = 15'h33;
      m_tag[11] = 15'h33; m_state[11] = INVALID;
      sb.push_back('{hit: 1'b1, hit_way: 4'd5, empty_valid: 1'b1, empty_way: 4'd11,
                     evict_way: 4'd11, chk_way: 4'd13, chk_ent: mem_ent(13)});
      run_req(9'd9, 15'h33, 1'b0, '0, '0, nul_e, 1'b0, '0, '0, nul_e, 1'b0);
   endtask

   task automatic test_forward_read();
      way_entry_t fe;
      fill_mem(INVALID, 'h40, 4'd6);
      m_tag[2] = 15'h55;
      fe = mk_ent(15'h12, 3'd1, rnd_line());
      sb.push_back('{hit: 1'b1, hit_way: 4'd2, empty_valid: 1'b1, empty_way: 4'd0,
                     evict_way: 4'd0, chk_way: 4'd2, chk_ent: fe});
      run_req(9'd5, 15'h12, 1'b1, 9'd5, 4'd2, fe,
              1'b1, 9'd6, 4'd0, mk_ent(15'h12, 3'd1, rnd_line()), 1'b0);
   endtask

   task automatic test_back_to_back();
      way_entry_t ea, eb;
      fill_mem(3'd3, 'h200, 4'd4);
      ea = mk_ent(15'h12, 3'd1, rnd_line());
      eb = mk_ent(15'h7f, 3'd2, rnd_line());
      sb.push_back('{hit: 1'b0, hit_way: 4'd0, empty_valid: 1'b0, empty_way: 4'd0,
                     evict_way: 4'd4, chk_way: 4'd6, chk_ent: eb});
      run_req(9'd5, 15'h12, 1'b1, 9'd5, 4'd6, ea, 1'b1, 9'd5, 4'd6, eb, 1'b0);
      // Immediate follow-up: the old forward must not leak into this fill.
      sb.push_back('{hit: 1'b1, hit_way: 4'd5, empty_valid: 1'b0, empty_way: 4'd0,
                     evict_way: 4'd4, chk_way: 4'd6, chk_ent: mem_ent(6)});
      run_req(9'd5, 15'h205, 1'b0, '0, '0, nul_e, 1'b0, '0, '0, nul_e, 1'b0);
   endtask

   task automatic test_hazard();
      setup_hit3();
      sb.push_back('{hit: 1'b1, hit_way: 4'd3, empty_valid: 1'b1, empty_way: 4'd0,
                     evict_way: 4'd0, chk_way: 4'd3, chk_ent: mem_ent(3)});
      run_req(9'd5, 15'h12, 1'b0, '0, '0, nul_e, 1'b0, '0, '0, nul_e, 1'b1);
      drive_wr(1'b1, 9'd6, 4'd3, mk_ent(15'h1, 3'd2, rnd_line()));
      @(posedge clk); #1;
      drive_wr(1'b0, '0, '0, nul_e);
      n_cmp++;
      if (hazard_err !== 1'b0 || buf_ent(3) !== mem_ent(3) || bufs_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL other_set_write: hazard=%b valid=%b way3=%h, required 0/1/%h",
                  hazard_err, bufs_valid, buf_ent(3), mem_ent(3));
      end
      drive_wr(1'b1, 9'd5, 4'd3, mk_ent(15'h1, 3'd2, rnd_line()));
      @(posedge clk); #1;
      drive_wr(1'b0, '0, '0, nul_e);
      n_cmp++;
      if (hazard_err !== 1'b1 || buf_ent(3) !== mem_ent(3) || hit !== 1'b1 ||
          hit_way !== 4'd3) begin
         n_fail++;
         $display("FAIL held_set_write: hazard=%b hit=%b/%0d way3=%h, required 1/1/3/%h",
                  hazard_err, hit, hit_way, buf_ent(3), mem_ent(3));
      end
      ack_done();
      @(posedge clk); #1;
      n_cmp++;
      if (hazard_err !== 1'b1) begin
         n_fail++;
         $display("FAIL hazard_sticky: hazard=%b, required 1", hazard_err);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req_valid = 1'b1; req_set = 9'd5; req_tag = 15'h12;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (bufs_valid !== 1'b0 || rd_en !== 1'b0 || hazard_err !== 1'b0 || hit !== 1'b0 ||
          tags_buf !== '0 || states_buf !== '0) begin
         n_fail++;
         $display("FAIL reset_in_capture: valid=%b rd_en=%b hazard=%b hit=%b, required all 0",
                  bufs_valid, rd_en, hazard_err, hit);
      end
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_reset: req_ready=%b, required 1", req_ready);
      end
      setup_hit3();
      sb.push_back('{hit: 1'b1, hit_way: 4'd3, empty_valid: 1'b1, empty_way: 4'd0,
                     evict_way: 4'd0, chk_way: 4'd3, chk_ent: mem_ent(3)});
      run_req(9'd5, 15'h12, 1'b0, '0, '0, nul_e, 1'b0, '0, '0, nul_e, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_hit();
      test_miss_evict();
      test_forward_read();
      test_back_to_back();
      test_hazard();
      test_reset_mid();
      n_cmp++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/llc_set_fill.md
Name: llc_set_fill

Overview:
- Read-side counterpart to the LLC set write-back stage.
- Reads every way of one LLC set from the per-way tag/state/line/metadata memories into the set buffers.
- Forwards in-flight write-back data into those buffers, then computes hit, empty-way and evict-way.
- Holds the buffered set for the process stage until it is acknowledged.

Parameters:
WAYS, 16, number of LLC ways (power of two)
WAY_W, 4, log2(WAYS)
SET_W, 9, set index width
TAG_W, 15, tag width
LINE_W, 128, cache line width
STATE_W, 3, LLC state width; INVALID encoding is 0
HPROT_W, 1, hprot width
SHARERS_W, 16, sharers vector width
OWNER_W, 4, owner id width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  lookup request
req_ready  out  1  high only in IDLE
req_set  in  SET_W  set to read
req_tag  in  TAG_W  tag to match
rd_en  out  1  memory read strobe, all ways
rd_set  out  SET_W  memory read address
rd_tags/rd_states/rd_lines/rd_hprots/rd_sharers/rd_owners/rd_dirty  in  WAYS*field  memory read data, valid 1 cycle after rd_en
rd_evict_way  in  WAY_W  per-set evict pointer read data
wr_en  in  1  write-back strobe from the update stage
wr_set  in  SET_W  write-back set
wr_way  in  WAY_W  write-back way
wr_tag/wr_state/wr_line/wr_hprot/wr_sharers/wr_owner/wr_dirty  in  field  write-back data
tags_buf/states_buf/lines_buf/hprots_buf/sharers_buf/owners_buf/dirty_bits_buf  out  WAYS*field  buffered set
evict_way_buf  out  WAY_W  buffered evict pointer
bufs_valid  out  1  buffers and lookup results valid
bufs_ack  in  1  consumer releases the buffers
hit  out  1  a non-INVALID way matches req_tag
hit_way  out  WAY_W  lowest matching way
empty_valid  out  1  some way is INVALID
empty_way  out  WAY_W  lowest INVALID way
evict_way  out  WAY_W  empty_way if empty_valid, else evict_way_buf
hazard_err  out  1  sticky: write to the held set in LOOKUP/DONE

Behaviour:
- Reset (async, any state): FSM goes to IDLE. All buffers, results, bufs_valid, rd_en and hazard_err are 0. req_ready is 1 after reset deasserts.
- FSM states: IDLE, READ, CAPTURE, LOOKUP, DONE.
- IDLE: req_ready=1. When req_valid is high at an edge, latch set and tag, then go to READ.
- READ (1 cycle): rd_en=1 and rd_set=the latched set. If wr_en and wr_set==set, record a pending forward (way and all fields). Memory is read-before-write, so this data is otherwise missed. Next state is CAPTURE.
- CAPTURE (1 cycle): register rd_* into the buffers, then apply overrides in this order:
  - the pending forward first;
  - then any wr_en with wr_set==set in this cycle, which wins on the same way.
  - Next state is LOOKUP.
- LOOKUP (1 cycle): register hit, hit_way, empty_valid, empty_way and evict_way from the buffers. Way selection is lowest index first. Next state is DONE.
- DONE: bufs_valid=1; buffers and results are stable. On bufs_ack, go to IDLE; bufs_valid drops in the next cycle.
- Latency: request accepted at edge T gives bufs_valid high from cycle T+4. Maximum throughput is one set per 5 cycles with immediate ack.
- Writes with wr_set!=set are ignored in every state.
- A write with wr_set==set during LOOKUP or DONE:
  - sets hazard_err, which stays set until reset;
  - leaves the buffers unchanged.
- rd_en is never asserted outside READ.
- req_ready is 0 in every state except IDLE.
- bufs_ack outside DONE is ignored.
- Pending forward is cleared on leaving CAPTURE and on reset.

Decomposition:
- Shared package: field typedefs (llc_tag_t, llc_state_t, line_t, hprot_t, sharers_t, owner_t, llc_way_t, llc_set_t), the INVALID state constant, and the fill FSM state enum.
- One sub-module, llc_way_select: a combinational lowest-index priority encoder (WAYS-bit vector in, valid+way out). It is instantiated twice, for hit and for empty.

Test Plan:
1. Reset, req set=5 tag=0x12; memory way 3 has tag 0x12, state VALID, all other ways INVALID -> rd_en only at T+1 with rd_set=5; bufs_valid at T+4; hit=1, hit_way=3, empty_way=0, evict_way=0.
2. All ways valid, no tag match, rd_evict_way=7 -> hit=0, empty_valid=0, evict_way=7.
3. wr_en set=5 way=2 state VALID tag 0x12 during READ, memory returns way 2 INVALID -> states_buf[2]=VALID, hit=1, hit_way=2.
4. wr_en same set and way in both READ (line A) and CAPTURE (line B) -> lines_buf[way]=B.
5. In DONE, wr_en set=5 -> hazard_err=1, buffers unchanged; wr_en set=6 in DONE -> no effect.
6. rst asserted in CAPTURE -> outputs 0 immediately; after release req_ready=1 and the next request completes normally in 4 cycles.
